// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared control-signal definitions for the pipeline hazard/stall controller.
//   xpr_t          : architectural register index
//   hazard_state_t : data-memory wait FSM encoding (RUN=0, WAIT=1, TRAP=2)
package hazard_stall_ctrl_pkg;

    localparam int unsigned XPR_WIDTH = 5;

    typedef logic [XPR_WIDTH-1:0] xpr_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        TRAP = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/hazard_stall_ctrl_wait_fsm.sv
// Data-memory wait-state tracker with bus-hang timeout.
// Ports:
//   CLK, RST    : core clock, asynchronous active-high reset
//   mem_req     : MEM stage has an access outstanding
//   mem_ready   : data memory completes the access this cycle
//   state       : RUN / WAIT / TRAP
//   mem_timeout : sticky flag, set on entry to TRAP
module mem_wait_fsm
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          mem_req,
    input  logic          mem_ready,
    output hazard_state_t state,
    output logic          mem_timeout
);

    localparam int unsigned WC_W = $clog2(TIMEOUT + 1);

    hazard_state_t   state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_q, timeout_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d    = WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            WAIT: begin
                // A dropped request is a protocol violation; treat it as completion.
                if (mem_ready || !mem_req) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WC_W'(TIMEOUT)) begin
                    state_d   = TRAP;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    assign state       = state_q;
    assign mem_timeout = timeout_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central hazard/stall controller for the 5-stage RV32 pipeline.
// Produces STALL/CLEAR strobes for IF/ID, ID/EX, EX/MEM and MEM/WB from
// load-use hazards, taken-branch redirects and data-memory wait states.
// Ports:
//   CLK, RST                     : core clock, asynchronous active-high reset
//   id_rs1/id_rs2, id_uses_rs*   : source operands of the ID instruction
//   ex_rd, ex_regwrite, ex_is_load, ex_branch_taken : EX instruction info
//   mem_req, mem_ready           : data-memory handshake from MEM
//   perf_clr                     : synchronous clear of stall_cycles
//   stall_* / clear_*            : pipeline register controls (combinational)
//   mem_timeout, state           : wait FSM trap flag and state
//   stall_cycles                 : saturating count of cycles with stall_pc=1
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned XPR_W   = XPR_WIDTH,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [XPR_W-1:0] id_rs1,
    input  logic [XPR_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [XPR_W-1:0] ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             perf_clr,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             clear_if_id,
    output logic             stall_id_ex,
    output logic             clear_id_ex,
    output logic             stall_ex_mem,
    output logic             clear_ex_mem,
    output logic             stall_mem_wb,
    output logic             clear_mem_wb,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles
);

    hazard_state_t fsm_state;
    logic          mem_stall, lu, flush, lu_eff;

    mem_wait_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_fsm (
        .CLK         (CLK),
        .RST         (RST),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .state       (fsm_state),
        .mem_timeout (mem_timeout)
    );

    assign state = fsm_state;

    // Priority: memory wait > branch flush > load-use. A flush kills the
    // wrong-path ID instruction, so its load-use hazard is moot.
    assign mem_stall = (mem_req & ~mem_ready) | (fsm_state == TRAP);
    assign lu        = ex_is_load & ex_regwrite & (ex_rd != '0) &
                       ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                        (id_uses_rs2 & (id_rs2 == ex_rd)));
    assign flush     = ex_branch_taken & ~mem_stall;
    assign lu_eff    = lu & ~flush & ~mem_stall;

    assign stall_pc     = mem_stall | lu_eff;
    assign stall_if_id  = mem_stall | lu_eff;
    assign clear_if_id  = flush;
    assign stall_id_ex  = mem_stall;
    assign clear_id_ex  = flush | lu_eff;
    assign stall_ex_mem = mem_stall;
    assign clear_ex_mem = 1'b0;
    assign stall_mem_wb = 1'b0;
    assign clear_mem_wb = mem_stall;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cycles <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
        end else if (stall_pc && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: scenario tasks push expected
// cycle results into a scoreboard queue and pop/compare at the falling edge.
module tb_hazard_stall_ctrl;

    localparam int unsigned TB_TIMEOUT = 4;
    localparam int unsigned TB_CNT_W   = 10;
    localparam int          CNT_MAX    = (1 << TB_CNT_W) - 1;
    localparam int unsigned VW         = 12 + TB_CNT_W;

    // strobe vector: {stall_pc, stall_if_id, clear_if_id, stall_id_ex, clear_id_ex,
    //                 stall_ex_mem, clear_ex_mem, stall_mem_wb, clear_mem_wb}
    localparam logic [8:0] NONE = 9'b000000000;
    localparam logic [8:0] LU   = 9'b110010000;
    localparam logic [8:0] FL   = 9'b001010000;
    localparam logic [8:0] MS   = 9'b110101001;
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_TRAP = 2'd2;

    typedef logic [VW-1:0] vec_t;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, ld, rw, br, rq, rdy, pc;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [8:0] strb;
        logic [1:0] st;
        logic       tmo;
    } step_t;

    logic                CLK, RST;
    logic [4:0]          id_rs1, id_rs2, ex_rd;
    logic                id_uses_rs1, id_uses_rs2, ex_regwrite, ex_is_load;
    logic                ex_branch_taken, mem_req, mem_ready, perf_clr;
    logic                stall_pc, stall_if_id, clear_if_id, stall_id_ex, clear_id_ex;
    logic                stall_ex_mem, clear_ex_mem, stall_mem_wb, clear_mem_wb;
    logic                mem_timeout;
    logic [1:0]          state;
    logic [TB_CNT_W-1:0] stall_cycles;

    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    vec_t sb[$];

    hazard_stall_ctrl #(
        .XPR_W   (5),
        .TIMEOUT (TB_TIMEOUT),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_regwrite     (ex_regwrite),
        .ex_is_load      (ex_is_load),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .perf_clr        (perf_clr),
        .stall_pc        (stall_pc),
        .stall_if_id     (stall_if_id),
        .clear_if_id     (clear_if_id),
        .stall_id_ex     (stall_id_ex),
        .clear_id_ex     (clear_id_ex),
        .stall_ex_mem    (stall_ex_mem),
        .clear_ex_mem    (clear_ex_mem),
        .stall_mem_wb    (stall_mem_wb),
        .clear_mem_wb    (clear_mem_wb),
        .mem_timeout     (mem_timeout),
        .state           (state),
        .stall_cycles    (stall_cycles)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic stim_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                                 input int rd, input bit ld, input bit rw, input bit br,
                                 input bit rq, input bit rdy, input bit pc);
        stim_t s;
        s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd);
        s.u1 = u1; s.u2 = u2; s.ld = ld; s.rw = rw;
        s.br = br; s.rq = rq; s.rdy = rdy; s.pc = pc;
        return s;
    endfunction

    function automatic step_t stp(input stim_t s, input logic [8:0] strb,
                                  input logic [1:0] st, input logic tmo);
        step_t t;
        t.s = s; t.strb = strb; t.st = st; t.tmo = tmo;
        return t;
    endfunction

    function automatic vec_t dut_vec();
        return {stall_pc, stall_if_id, clear_if_id, stall_id_ex, clear_id_ex,
                stall_ex_mem, clear_ex_mem, stall_mem_wb, clear_mem_wb,
                state, mem_timeout, stall_cycles};
    endfunction

    task automatic apply(input stim_t s);
        id_rs1 = s.rs1; id_rs2 = s.rs2; id_uses_rs1 = s.u1; id_uses_rs2 = s.u2;
        ex_rd = s.rd; ex_is_load = s.ld; ex_regwrite = s.rw; ex_branch_taken = s.br;
        mem_req = s.rq; mem_ready = s.rdy; perf_clr = s.pc;
    endtask

    // Queue the expected view of this cycle, then advance the counter model
    // to what the next rising edge should produce.
    task automatic push_exp(input logic [8:0] strb, input logic [1:0] st, input logic tmo);
        sb.push_back({strb, st, tmo, exp_cnt[TB_CNT_W-1:0]});
        if (perf_clr) exp_cnt = 0;
        else if (strb[8] && exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
    endtask

    // A register must never see stall and clear together.
    always @(negedge CLK) begin
        checks++;
        if ((stall_if_id && clear_if_id) || (stall_id_ex && clear_id_ex) ||
            (stall_ex_mem && clear_ex_mem) || (stall_mem_wb && clear_mem_wb)) begin
            errors++;
            $display("FAIL stall_clear_overlap t=%0t got=%b exp=no overlap", $time,
                     {stall_if_id, clear_if_id, stall_id_ex, clear_id_ex,
                      stall_ex_mem, clear_ex_mem, stall_mem_wb, clear_mem_wb});
        end
    end

    task automatic test_reset();
        vec_t got, exp_v;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            if (i == 0) apply(mk(0,0,0,0,0,0,0,0,0,0,0));
            else        apply(mk(0,0,0,0,0,0,0,0,1,0,0));
            push_exp((i == 0) ? NONE : MS, S_RUN, 1'b0);
            @(negedge CLK);
            exp_v = sb.pop_front(); got = dut_vec(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL reset[%0d] got=%h exp=%h", i, got, exp_v);
            end
        end
        apply(mk(0,0,0,0,0,0,0,0,0,0,0));
        exp_cnt = 0;
        #1 RST = 1'b0;
    endtask

    task automatic test_load_use();
        step_t t[$];
        vec_t got, exp_v;
        t.push_back(stp(mk(5,0,1,0,5,1,1,0,0,0,0), LU,   S_RUN, 1'b0));
        t.push_back(stp(mk(0,0,0,0,0,0,0,0,0,0,0), NONE, S_RUN, 1'b0));
        t.push_back(stp(mk(0,7,0,1,7,1,1,0,0,0,0), LU,   S_RUN, 1'b0));
        t.push_back(stp(mk(7,0,0,1,7,1,1,0,0,0,0), NONE, S_RUN, 1'b0));
        t.push_back(stp(mk(5,0,1,0,5,0,1,0,0,0,0), NONE, S_RUN, 1'b0));
        t.push_back(stp(mk(5,0,1,0,5,1,0,0,0,0,0), NONE, S_RUN, 1'b0));
        t.push_back(stp(mk(5,5,1,1,6,1,1,0,0,0,0), NONE, S_RUN, 1'b0));
        t.push_back(stp(mk(31,9,1,1,31,1,1,0,0,0,0), LU, S_RUN, 1'b0));
        t.push_back(stp(mk(0,0,0,0,0,0,0,0,0,0,0), NONE, S_RUN, 1'b0));
        foreach (t[i]) begin
            @(posedge CLK); #1;
            apply(t[i].s);
            push_exp(t[i].strb, t[i].st, t[i].tmo);
            @(negedge CLK);
            exp_v = sb.pop_front(); got = dut_vec(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL load_use[%0d] got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_x0();
        step_t t[$];
        vec_t got, exp_v;
        t.push_back(stp(mk(0,0,1,0,0,1,1,0,0,0,0), NONE, S_RUN, 1'b0));
        t.push_back(stp(mk(3,0,0,1,0,1,1,0,0,0,0), NONE, S_RUN, 1'b0));
        foreach (t[i]) begin
            @(posedge CLK); #1;
            apply(t[i].s);
            push_exp(t[i].strb, t[i].st, t[i].tmo);
            @(negedge CLK);
            exp_v = sb.pop_front(); got = dut_vec(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL load_x0[%0d] got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_branch();
        step_t t[$];
        vec_t got, exp_v;
        t.push_back(stp(mk(5,0,1,0,5,1,1,1,0,0,0), FL,   S_RUN, 1'b0));
        t.push_back(stp(mk(0,0,0,0,0,0,0,1,0,0,0), FL,   S_RUN, 1'b0));
        t.push_back(stp(mk(0,0,0,0,0,0,0,0,0,0,0), NONE, S_RUN, 1'b0));
        foreach (t[i]) begin
            @(posedge CLK); #1;
            apply(t[i].s);
            push_exp(t[i].strb, t[i].st, t[i].tmo);
            @(negedge CLK);
            exp_v = sb.pop_front(); got = dut_vec(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL branch[%0d] got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_mem_wait();
        step_t t[$];
        vec_t got, exp_v;
        t.push_back(stp(mk(0,0,0,0,0,0,0,1,1,0,0), MS,   S_RUN,  1'b0));
        t.push_back(stp(mk(0,0,0,0,0,0,0,1,1,0,0), MS,   S_WAIT, 1'b0));
        t.push_back(stp(mk(0,0,0,0,0,0,0,1,1,0,0), MS,   S_WAIT, 1'b0));
        t.push_back(stp(mk(0,0,0,0,0,0,0,1,1,1,0), FL,   S_WAIT, 1'b0));
        t.push_back(stp(mk(0,0,0,0,0,0,0,0,0,0,0), NONE, S_RUN,  1'b0));
        t.push_back(stp(mk(0,0,0,0,0,0,0,0,1,1,0), NONE, S_RUN,  1'b0));
        t.push_back(stp(mk(0,0,0,0,0,0,0,0,0,0,0), NONE, S_RUN,  1'b0));
        t.push_back(stp(mk(5,0,1,0,5,1,1,0,1,0,0), MS,   S_RUN,  1'b0));
        t.push_back(stp(mk(0,0,0,0,0,0,0,0,0,0,0), NONE, S_WAIT, 1'b0));
        t.push_back(stp(mk(0,0,0,0,0,0,0,0,0,0,0), NONE, S_RUN,  1'b0));
        foreach (t[i]) begin
            @(posedge CLK); #1;
            apply(t[i].s);
            push_exp(t[i].strb, t[i].st, t[i].tmo);
            @(negedge CLK);
            exp_v = sb.pop_front(); got = dut_vec(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL mem_wait[%0d] got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        vec_t got, exp_v;
        @(posedge CLK); #1;
        apply(mk(0,0,0,0,0,0,0,0,1,0,0));
        push_exp(MS, S_RUN, 1'b0);
        @(negedge CLK);
        exp_v = sb.pop_front(); got = dut_vec(); checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL rst_wait_pre0 got=%h exp=%h", got, exp_v);
        end
        @(posedge CLK); #1;
        push_exp(MS, S_WAIT, 1'b0);
        @(negedge CLK);
        exp_v = sb.pop_front(); got = dut_vec(); checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL rst_wait_pre1 got=%h exp=%h", got, exp_v);
        end
        #2;
        apply(mk(0,0,0,0,0,0,0,0,0,0,0));
        RST = 1'b1;
        exp_cnt = 0;
        #1;
        push_exp(NONE, S_RUN, 1'b0);
        exp_v = sb.pop_front(); got = dut_vec(); checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL rst_wait_async got=%h exp=%h", got, exp_v);
        end
        RST = 1'b0;
    endtask

    task automatic test_timeout();
        step_t t[$];
        vec_t got, exp_v;
        for (int i = 0; i < 5; i++)
            t.push_back(stp(mk(0,0,0,0,0,0,0,0,1,0,0), MS, (i == 0) ? S_RUN : S_WAIT, 1'b0));
        t.push_back(stp(mk(0,0,0,0,0,0,0,0,1,1,0), MS, S_TRAP, 1'b1));
        t.push_back(stp(mk(5,0,1,0,5,1,1,1,0,0,0), MS, S_TRAP, 1'b1));
        foreach (t[i]) begin
            @(posedge CLK); #1;
            apply(t[i].s);
            push_exp(t[i].strb, t[i].st, t[i].tmo);
            @(negedge CLK);
            exp_v = sb.pop_front(); got = dut_vec(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL timeout[%0d] got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_saturation();
        step_t t[$];
        vec_t got, exp_v;
        t.push_back(stp(mk(0,0,0,0,0,0,0,0,0,0,1), MS, S_TRAP, 1'b1));
        for (int i = 0; i < CNT_MAX + 4; i++)
            t.push_back(stp(mk(0,0,0,0,0,0,0,0,0,0,0), MS, S_TRAP, 1'b1));
        t.push_back(stp(mk(0,0,0,0,0,0,0,0,0,0,1), MS, S_TRAP, 1'b1));
        t.push_back(stp(mk(0,0,0,0,0,0,0,0,0,0,0), MS, S_TRAP, 1'b1));
        t.push_back(stp(mk(0,0,0,0,0,0,0,0,0,0,0), MS, S_TRAP, 1'b1));
        foreach (t[i]) begin
            @(posedge CLK); #1;
            apply(t[i].s);
            push_exp(t[i].strb, t[i].st, t[i].tmo);
            @(negedge CLK);
            exp_v = sb.pop_front(); got = dut_vec(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL saturate[%0d] got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_trap();
        vec_t got, exp_v;
        #2;
        apply(mk(0,0,0,0,0,0,0,0,0,0,0));
        RST = 1'b1;
        exp_cnt = 0;
        #1;
        push_exp(NONE, S_RUN, 1'b0);
        exp_v = sb.pop_front(); got = dut_vec(); checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL rst_trap_async got=%h exp=%h", got, exp_v);
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        push_exp(NONE, S_RUN, 1'b0);
        @(negedge CLK);
        exp_v = sb.pop_front(); got = dut_vec(); checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL rst_trap_after got=%h exp=%h", got, exp_v);
        end
    endtask

    initial begin
        RST = 1'b1;
        apply(mk(0,0,0,0,0,0,0,0,0,0,0));
        test_reset();
        test_load_use();
        test_x0();
        test_branch();
        test_mem_wait();
        test_reset_mid_wait();
        test_timeout();
        test_saturation();
        test_reset_mid_trap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
